// File: rtl/rx_pack_fifo_pkg.sv
// ---------------------------------------------------------------------------
// rx_pack_fifo_pkg
// Shared defaults for the receive packing FIFO and a helper that sizes one
// stored entry. No ports; imported by the interface, the RAM and the top.
// ---------------------------------------------------------------------------
package rx_pack_fifo_pkg;

  localparam int RX_PACK_DATA_WIDTH    = 32;
  localparam int RX_PACK_MAX_NUM_LANES = 4;
  localparam int RX_PACK_DEPTH         = 8;

  // Per lane sideband carried with the data: 2 sync header bits,
  // 4 K flags and 1 lane-valid bit.
  localparam int RX_PACK_SIDEBAND_BITS = 7;

  function automatic int rx_pack_entry_width(input int data_width, input int num_lanes);
    return num_lanes * (data_width + RX_PACK_SIDEBAND_BITS);
  endfunction

endpackage

// File: rtl/rx_pack_fifo_if.sv
// ---------------------------------------------------------------------------
// rx_pack_fifo_if
// Bundles the packer-side write bus, the link state, and the data-link-side
// read handshake plus status for rx_pack_fifo.
//   slave  : the FIFO view (beat/strobe/ready in, head beat/status out)
//   master : the environment view (packer + consumer), the mirror of slave
// ---------------------------------------------------------------------------
interface rx_pack_fifo_if
  import rx_pack_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = RX_PACK_DATA_WIDTH,
  parameter int MAX_NUM_LANES = RX_PACK_MAX_NUM_LANES,
  parameter int DEPTH         = RX_PACK_DEPTH
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                                phy_link_up_i;
  logic                                fifo_wr_i;
  logic [MAX_NUM_LANES*DATA_WIDTH-1:0] data_i;
  logic [MAX_NUM_LANES-1:0]            data_valid_i;
  logic [4*MAX_NUM_LANES-1:0]          data_k_i;
  logic [2*MAX_NUM_LANES-1:0]          sync_header_i;

  logic [MAX_NUM_LANES*DATA_WIDTH-1:0] data_o;
  logic [MAX_NUM_LANES-1:0]            data_valid_o;
  logic [4*MAX_NUM_LANES-1:0]          data_k_o;
  logic [2*MAX_NUM_LANES-1:0]          sync_header_o;
  logic                                valid_o;
  logic                                ready_i;

  logic                                full_o;
  logic                                empty_o;
  logic [CW-1:0]                       count_o;
  logic                                overflow_o;

  modport slave (
    input  phy_link_up_i, fifo_wr_i, data_i, data_valid_i, data_k_i, sync_header_i, ready_i,
    output data_o, data_valid_o, data_k_o, sync_header_o, valid_o,
           full_o, empty_o, count_o, overflow_o
  );

  modport master (
    output phy_link_up_i, fifo_wr_i, data_i, data_valid_i, data_k_i, sync_header_i, ready_i,
    input  data_o, data_valid_o, data_k_o, sync_header_o, valid_o,
           full_o, empty_o, count_o, overflow_o
  );

endinterface

// File: rtl/rx_pack_ram.sv
// ---------------------------------------------------------------------------
// rx_pack_ram
// DEPTH x WIDTH register array: one synchronous write port, one
// combinational read port, no reset (contents are only ever observed
// through the FIFO's gated outputs).
//   clk_i      clock
//   wr_en_i    write enable
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_addr_i  read address
//   rd_data_o  read data (combinational)
// ---------------------------------------------------------------------------
module rx_pack_ram
  import rx_pack_fifo_pkg::*;
#(
  parameter int WIDTH = rx_pack_entry_width(RX_PACK_DATA_WIDTH, RX_PACK_MAX_NUM_LANES),
  parameter int DEPTH = RX_PACK_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/rx_pack_fifo.sv
// ---------------------------------------------------------------------------
// rx_pack_fifo
// Elastic buffer after the receive packer. Captures one packed beat
// {sync_header, data_k, data_valid, data} per write strobe and presents the
// beats in order to the data-link side over valid/ready. Link-down flushes
// the contents so no stale framing survives a retrain.
//   clk_i  clock
//   rst_i  synchronous active-high reset
//   bus    rx_pack_fifo_if.slave: write beat/strobe, link state, read
//          handshake, head beat, full/empty/count and overflow pulse
// ---------------------------------------------------------------------------
module rx_pack_fifo
  import rx_pack_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = RX_PACK_DATA_WIDTH,
  parameter int MAX_NUM_LANES = RX_PACK_MAX_NUM_LANES,
  parameter int DEPTH         = RX_PACK_DEPTH
) (
  input logic           clk_i,
  input logic           rst_i,
  rx_pack_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = rx_pack_entry_width(DATA_WIDTH, MAX_NUM_LANES);

  localparam int DATA_LSB  = 0;
  localparam int VALID_LSB = DATA_LSB + MAX_NUM_LANES * DATA_WIDTH;
  localparam int K_LSB     = VALID_LSB + MAX_NUM_LANES;
  localparam int SYNC_LSB  = K_LSB + 4 * MAX_NUM_LANES;

  typedef logic [PW-1:0] ptr_t;
  localparam ptr_t PTR_ONE = ptr_t'(1);

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  logic overflow_q, overflow_d;

  logic          empty;
  logic          full;
  logic          head_valid;
  logic          wr_accept;
  logic          rd_accept;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;

  // The MSB of each pointer is a wrap bit, so equal index bits mean either
  // empty (same lap) or full (writer one lap ahead).
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // Full blocks writes even if a read happens in the same cycle, which keeps
  // the packer side free of any combinational dependency on ready_i.
  assign head_valid = !empty && bus.phy_link_up_i;
  assign wr_accept  = bus.fifo_wr_i && !full && bus.phy_link_up_i;
  assign rd_accept  = head_valid && bus.ready_i;

  assign wr_entry = {bus.sync_header_i, bus.data_k_i, bus.data_valid_i, bus.data_i};

  // Link-down clears both pointers every cycle and suppresses the overflow
  // pulse; otherwise pointers advance on accepted transfers.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = 1'b0;
    if (!bus.phy_link_up_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_accept) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      overflow_d = bus.fifo_wr_i && full;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  rx_pack_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (wr_accept),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_data_i (wr_entry),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (rd_entry)
  );

  // Head fields are zeroed while empty so stale RAM contents (including
  // those left behind by a reset or flush) never reach the consumer.
  always_comb begin
    bus.data_o        = '0;
    bus.data_valid_o  = '0;
    bus.data_k_o      = '0;
    bus.sync_header_o = '0;
    if (!empty) begin
      bus.data_o        = rd_entry[DATA_LSB  +: MAX_NUM_LANES*DATA_WIDTH];
      bus.data_valid_o  = rd_entry[VALID_LSB +: MAX_NUM_LANES];
      bus.data_k_o      = rd_entry[K_LSB     +: 4*MAX_NUM_LANES];
      bus.sync_header_o = rd_entry[SYNC_LSB  +: 2*MAX_NUM_LANES];
    end
  end

  assign bus.valid_o    = head_valid;
  assign bus.full_o     = full;
  assign bus.empty_o    = empty;
  assign bus.count_o    = wr_ptr_q - rd_ptr_q;
  assign bus.overflow_o = overflow_q;

endmodule

// File: tb/tb_rx_pack_fifo.sv
// ---------------------------------------------------------------------------
// tb_rx_pack_fifo
// Scoreboard bench for rx_pack_fifo. The stimulus task keeps a queue of the
// beats the FIFO should hold; a negedge monitor compares the DUT's status and
// head beat against that queue and retires the head on each handshake.
// ---------------------------------------------------------------------------
module tb_rx_pack_fifo;
  import rx_pack_fifo_pkg::*;

  localparam int DW    = 32;
  localparam int L     = 4;
  localparam int DEPTH = 8;
  localparam int EW    = L * (DW + 7);
  localparam int RW    = 32 * ((EW + 31) / 32);

  typedef logic [EW-1:0] entry_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rx_pack_fifo_if #(.DATA_WIDTH(DW), .MAX_NUM_LANES(L), .DEPTH(DEPTH)) bus ();

  rx_pack_fifo #(
    .DATA_WIDTH    (DW),
    .MAX_NUM_LANES (L),
    .DEPTH         (DEPTH)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // Reference state: beats the FIFO should hold, plus what the monitor
  // should observe during the current cycle.
  entry_t exp_q[$];
  int     exp_occ     = 0;
  entry_t exp_head    = '0;
  logic   exp_ovf     = 1'b0;
  logic   pending_ovf = 1'b0;
  logic   check_en    = 1'b0;
  logic   cur_rst     = 1'b1;
  logic   cur_link    = 1'b1;
  logic   cur_ready   = 1'b0;

  int n_compared   = 0;
  int n_mismatched = 0;

  entry_t dut_entry;
  assign dut_entry = {bus.sync_header_o, bus.data_k_o, bus.data_valid_o, bus.data_o};

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic entry_t makeEntry(input logic [2*L-1:0] sync, input logic [4*L-1:0] k,
                                       input logic [L-1:0] valid, input logic [L*DW-1:0] data);
    return {sync, k, valid, data};
  endfunction

  function automatic entry_t randEntry();
    logic [RW-1:0] tmp;
    for (int i = 0; i < RW / 32; i++) begin
      tmp[i*32 +: 32] = $urandom;
    end
    return tmp[EW-1:0];
  endfunction

  // One clock of stimulus: snapshot what the monitor should see this cycle,
  // then update the reference queue for the coming edge and drive the DUT.
  task automatic applyStimulus(input logic r, input logic l, input logic w, input logic rd,
                               input entry_t e);
    @(posedge clk);
    #1;
    exp_occ  = exp_q.size();
    exp_head = (exp_q.size() != 0) ? exp_q[0] : '0;
    exp_ovf  = pending_ovf;
    pending_ovf = !r && l && w && (exp_q.size() >= DEPTH);
    if (r || !l) begin
      exp_q.delete();
    end else if (w && exp_q.size() < DEPTH) begin
      exp_q.push_back(e);
    end
    cur_rst   = r;
    cur_link  = l;
    cur_ready = rd;
    rst               = r;
    bus.phy_link_up_i = l;
    bus.fifo_wr_i     = w;
    bus.ready_i       = rd;
    bus.data_i        = e[0 +: L*DW];
    bus.data_valid_i  = e[L*DW +: L];
    bus.data_k_i      = e[L*DW+L +: 4*L];
    bus.sync_header_i = e[L*DW+5*L +: 2*L];
  endtask

  // Monitor: status every cycle, head beat when present, and retire the
  // expected head when the consumer takes it at the next edge.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("count",    256'(bus.count_o),    256'(exp_occ));
      checkOutput("empty",    256'(bus.empty_o),    256'(exp_occ == 0));
      checkOutput("full",     256'(bus.full_o),     256'(exp_occ == DEPTH));
      checkOutput("valid",    256'(bus.valid_o),    256'(exp_occ != 0 && cur_link));
      checkOutput("overflow", 256'(bus.overflow_o), 256'(exp_ovf));
      if (exp_occ == 0) begin
        checkOutput("head_zero", 256'(dut_entry), 256'(0));
      end else if (cur_link) begin
        checkOutput("head", 256'(dut_entry), 256'(exp_head));
      end
      if (exp_occ != 0 && cur_link && !cur_rst && cur_ready) begin
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    entry_t stp;
    rst               = 1'b1;
    bus.phy_link_up_i = 1'b1;
    bus.fifo_wr_i     = 1'b0;
    bus.ready_i       = 1'b0;
    bus.data_i        = '0;
    bus.data_valid_i  = '0;
    bus.data_k_i      = '0;
    bus.sync_header_i = '0;
    repeat (2) @(posedge clk);
    check_en = 1'b1;

    // Reset then idle
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // Single STP beat on lane 0, then consume it
    stp = makeEntry('0, 16'h0001, 4'b0001, (L*DW)'(32'h0000_00FB));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, stp);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, '0);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // Fill to full, one dropped write, then drain in order
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, randEntry());
    repeat (DEPTH + 2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, '0);

    // Streaming write+read with incrementing data
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, makeEntry(8'h55, '0, 4'hF, (L*DW)'(i + 1)));
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, '0);

    // Link-down flush with a write attempt during the drop
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, randEntry());
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, randEntry());
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, randEntry());
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, '0);

    // Reset while a read is being offered, then a fresh write
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, randEntry());
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, randEntry());
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, '0);

    // Random traffic with occasional link drops and resets
    for (int i = 0; i < 400; i++) begin
      logic r, l, w, rd;
      r  = ($urandom_range(63) == 0);
      l  = ($urandom_range(31) != 0);
      w  = ($urandom_range(9) < 6);
      rd = ($urandom_range(1) == 1);
      applyStimulus(r, l, w, rd, randEntry());
    end

    // Final drain
    repeat (DEPTH + 4) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, '0);

    @(negedge clk);
    #1;
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
